mtm_alu_ctrl: RTL and testbench

- Command sequencer between the deserializer, the ALU core and the serializer of the MTM ALU.
- Accepts one decoded command (A, B, OP) or an error indication from the deserializer, validates OP, and launches the ALU.
- Waits for completion with a timeout, then builds the response frame (result + CTL byte with flags and CRC3, or an error CTL byte).
- Holds the frame until the serializer accepts it.

---
 rtl/mtm_alu_pkg.sv | 50 +++++
 rtl/mtm_alu_ctrl_if.sv | 50 +++++
 rtl/mtm_alu_crc3.sv | 28 ++
 rtl/mtm_alu_ctrl.sv | 145 ++++++++++++++
 tb/tb_mtm_alu_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_pkg
// Brief    : Shared encodings for the MTM ALU command sequencer.
// Revision : 1.0
// ============================================================================
package mtm_alu_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_PACK  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_e;

    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEGATIVE = 0;

    // x^3 + x + 1 with the implicit x^3 term dropped
    localparam logic [2:0] CRC3_POLY = 3'b011;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    function automatic logic is_valid_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_ctrl_if
// Brief    : Deserializer, ALU and serializer signals around the sequencer.
// Revision : 1.0
// ============================================================================
interface mtm_alu_ctrl_if;

    logic        deser_valid;
    logic        deser_ready;
    logic [31:0] deser_A;
    logic [31:0] deser_B;
    logic [2:0]  deser_op;
    logic [5:0]  deser_err;

    logic        alu_start;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    logic        ser_valid;
    logic        ser_ready;
    logic        ser_is_err;
    logic [31:0] ser_data;
    logic [7:0]  ser_ctl;

    // slave: the sequencer itself; master: everything around it
    modport slave (
        input  deser_valid, deser_A, deser_B, deser_op, deser_err,
        input  alu_done, alu_result, alu_flags,
        input  ser_ready,
        output deser_ready,
        output alu_start, alu_A, alu_B, alu_op,
        output ser_valid, ser_is_err, ser_data, ser_ctl
    );

    modport master (
        output deser_valid, deser_A, deser_B, deser_op, deser_err,
        output alu_done, alu_result, alu_flags,
        output ser_ready,
        input  deser_ready,
        input  alu_start, alu_A, alu_B, alu_op,
        input  ser_valid, ser_is_err, ser_data, ser_ctl
    );

endinterface
`default_nettype wire

// File: rtl/mtm_alu_crc3.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_crc3
// Brief    : Combinational CRC3 over 37 bits, MSB first, init 3'b000.
// Revision : 1.0
// ============================================================================
module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  wire logic [36:0] i_data,
    output logic      [2:0]  o_crc
);

    logic [2:0] w_acc;
    logic       w_fb;

    always_comb begin
        w_acc = 3'b000;
        w_fb  = 1'b0;
        for (int i = 36; i >= 0; i--) begin
            w_fb  = w_acc[2] ^ i_data[i];
            w_acc = {w_acc[1:0], 1'b0} ^ (w_fb ? CRC3_POLY : 3'b000);
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/mtm_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_ctrl
// Brief    : Command sequencer: validate, launch ALU with timeout, frame reply.
// Revision : 1.0
// ============================================================================
module mtm_alu_ctrl
    import mtm_alu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mtm_alu_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(ALU_TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [2:0]       r_state;
    logic             r_deser_ready;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;
    logic [5:0]       r_err;
    logic             r_alu_start;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_result;
    alu_flags_t       r_flags;
    logic             r_ser_valid;
    logic             r_ser_is_err;
    logic [31:0]      r_ser_data;
    logic [7:0]       r_ser_ctl;

    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_crc;
    logic             w_err_par;

    assign w_cnt_next = r_cnt + c_one;
    assign w_err_par  = ^{1'b1, r_err};

    mtm_alu_crc3 u_crc (
        .i_data ({r_result, 1'b0, r_flags}),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_deser_ready <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_err         <= '0;
            r_alu_start   <= 1'b0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_flags       <= '0;
            r_ser_valid   <= 1'b0;
            r_ser_is_err  <= 1'b0;
            r_ser_data    <= '0;
            r_ser_ctl     <= '0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.deser_valid) begin
                        r_a           <= bus.deser_A;
                        r_b           <= bus.deser_B;
                        r_op          <= bus.deser_op;
                        r_err         <= bus.deser_err;
                        r_deser_ready <= 1'b0;
                        r_state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Deserializer errors outrank an illegal opcode
                    if (r_err != 6'd0) begin
                        r_state <= ST_PACK;
                    end else if (!is_valid_op(r_op)) begin
                        r_err   <= ERR_OP;
                        r_state <= ST_PACK;
                    end else begin
                        r_alu_start <= 1'b1;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // A done on the final cycle beats the timeout
                    if (bus.alu_done) begin
                        r_result <= bus.alu_result;
                        r_flags  <= bus.alu_flags;
                        r_state  <= ST_PACK;
                    end else if (w_cnt_next == c_timeout) begin
                        r_err   <= ERR_DATA;
                        r_state <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (r_err != 6'd0) begin
                        r_ser_data   <= '0;
                        r_ser_ctl    <= {1'b1, r_err, w_err_par};
                        r_ser_is_err <= 1'b1;
                    end else begin
                        r_ser_data   <= r_result;
                        r_ser_ctl    <= {1'b0, r_flags, w_crc};
                        r_ser_is_err <= 1'b0;
                    end
                    r_ser_valid <= 1'b1;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.ser_ready) begin
                        r_ser_valid   <= 1'b0;
                        r_deser_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_deser_ready <= 1'b1;
                    r_ser_valid   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.deser_ready = r_deser_ready;
    assign bus.alu_start   = r_alu_start;
    assign bus.alu_A       = r_a;
    assign bus.alu_B       = r_b;
    assign bus.alu_op      = r_op;
    assign bus.ser_valid   = r_ser_valid;
    assign bus.ser_is_err  = r_ser_is_err;
    assign bus.ser_data    = r_ser_data;
    assign bus.ser_ctl     = r_ser_ctl;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtm_alu_ctrl
// Brief    : Directed vector bench for the MTM ALU command sequencer.
// Revision : 1.0
// ============================================================================
module tb_mtm_alu_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mtm_alu_ctrl_if bus ();

    mtm_alu_ctrl #(
        .ALU_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [5:0]  err;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        logic [7:0]  alu_lat;    // 0: ALU never answers
        logic [7:0]  exp_lat;
        logic [1:0]  exp_starts;
        logic        exp_err;
        logic [7:0]  exp_ctl;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [0:9];
    vec_t vec_or;

    // Remainder of ({res,0,flags} * x^3) mod (x^3+x+1) by long division
    function automatic logic [2:0] crc3_model(input logic [31:0] r, input logic [3:0] f);
        logic [39:0] m;
        m = {r, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
        return m[2:0];
    endfunction

    function automatic vec_t data_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] res, input logic [3:0] flags, input int lat);
        vec_t v;
        v = '{op: op, err: 6'd0, a: a, b: b, res: res, flags: flags, alu_lat: 8'(lat),
              exp_lat: 8'(4 + lat), exp_starts: 2'd1, exp_err: 1'b0,
              exp_ctl: {1'b0, flags, crc3_model(res, flags)}, exp_data: res};
        return v;
    endfunction

    function automatic vec_t err_vec(input logic [2:0] op, input logic [5:0] err, input logic [7:0] ctl,
                                     input int lat, input int starts, input int alu_lat);
        vec_t v;
        v = '{op: op, err: err, a: 32'h1234_5678, b: 32'h9ABC_DEF0, res: 32'hDEAD_BEEF, flags: 4'hF,
              alu_lat: 8'(alu_lat), exp_lat: 8'(lat), exp_starts: 2'(starts), exp_err: 1'b1,
              exp_ctl: ctl, exp_data: 32'd0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic handshake();
        bus.ser_ready = 1'b1;
        @(posedge clk); #1;
        bus.ser_ready = 1'b0;
        chk("ser_valid after handshake", 64'(bus.ser_valid), 64'd0);
        chk("deser_ready after handshake", 64'(bus.deser_ready), 64'd1);
    endtask

    // Issue one command in the current cycle, play the ALU, check the frame
    task automatic apply(input vec_t v, input bit do_hs);
        int starts;
        int start_cyc;
        int lat;
        bit got;
        starts    = 0;
        start_cyc = -1;
        lat       = -1;
        got       = 1'b0;
        bus.deser_A     = v.a;
        bus.deser_B     = v.b;
        bus.deser_op    = v.op;
        bus.deser_err   = v.err;
        bus.deser_valid = 1'b1;
        for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(posedge clk); #1;
            bus.deser_valid = 1'b0;
            bus.alu_done    = 1'b0;
            if (bus.alu_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (start_cyc >= 0 && v.alu_lat != 0 && cyc == start_cyc + int'(v.alu_lat)) begin
                bus.alu_done   = 1'b1;
                bus.alu_result = v.res;
                bus.alu_flags  = v.flags;
            end
            if (bus.ser_valid) begin
                got = 1'b1;
                lat = cyc;
            end
        end
        chk("ser_valid seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("alu_start pulses", 64'(starts), 64'(v.exp_starts));
        chk("ser_is_err", 64'(bus.ser_is_err), 64'(v.exp_err));
        chk("ser_ctl", 64'(bus.ser_ctl), 64'(v.exp_ctl));
        chk("ser_data", 64'(bus.ser_data), 64'(v.exp_data));
        chk("alu_A", 64'(bus.alu_A), 64'(v.a));
        chk("alu_B", 64'(bus.alu_B), 64'(v.b));
        chk("alu_op", 64'(bus.alu_op), 64'(v.op));
        chk("deser_ready busy", 64'(bus.deser_ready), 64'd0);
        if (do_hs) handshake();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " deser_ready"}, 64'(bus.deser_ready), 64'd1);
        chk({tag, " alu_start"},   64'(bus.alu_start),   64'd0);
        chk({tag, " ser_valid"},   64'(bus.ser_valid),   64'd0);
        chk({tag, " ser_is_err"},  64'(bus.ser_is_err),  64'd0);
        chk({tag, " alu_A"},       64'(bus.alu_A),       64'd0);
        chk({tag, " alu_B"},       64'(bus.alu_B),       64'd0);
        chk({tag, " alu_op"},      64'(bus.alu_op),      64'd0);
        chk({tag, " ser_data"},    64'(bus.ser_data),    64'd0);
        chk({tag, " ser_ctl"},     64'(bus.ser_ctl),     64'd0);
    endtask

    // Watch for n cycles that nothing leaves the sequencer
    task automatic expect_quiet(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.alu_done = 1'b0;
            if (bus.ser_valid || bus.alu_start || !bus.deser_ready) bad++;
        end
        chk(name, 64'(bad), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_data;
        logic [7:0]  held_ctl;
        int          bad;
        int          busy_ready;

        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b1;
        bus.deser_valid = 1'b0;
        bus.deser_A     = '0;
        bus.deser_B     = '0;
        bus.deser_op    = '0;
        bus.deser_err   = '0;
        bus.alu_done    = 1'b0;
        bus.alu_result  = '0;
        bus.alu_flags   = '0;
        bus.ser_ready   = 1'b0;

        vecs[0] = data_vec(3'b100, 32'd1, 32'd2, 32'd3, 4'b0000, 2);
        vecs[0].exp_ctl = 8'h06;
        vecs[1] = err_vec(3'b010, 6'd0,       8'b1001_0011, 3,  0, 2);
        vecs[2] = err_vec(3'b100, 6'b010010,  8'b1010_0101, 3,  0, 2);
        vecs[3] = data_vec(3'b101, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b1001, 1);
        vecs[4] = data_vec(3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 3);
        vecs[5] = err_vec(3'b111, 6'd0,       8'b1001_0011, 3,  0, 2);
        vecs[6] = err_vec(3'b011, 6'b000001,  8'b1000_0010, 3,  0, 2);
        vecs[7] = err_vec(3'b100, 6'd0,       8'b1100_1001, 20, 1, 0);
        vecs[8] = data_vec(3'b001, 32'd0, 32'd0, 32'd0, 4'b0010, 16);
        vecs[9] = err_vec(3'b100, 6'd0,       8'b1100_1001, 20, 1, 17);
        vec_or  = data_vec(3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000, 1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) apply(vecs[i], 1'b1);

        // Late alu_done while idle must not produce a frame
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'h5555_5555;
        expect_quiet("late alu_done ignored", 6);

        // Serializer back-pressure with a dropped command in the middle
        apply(vecs[0], 1'b0);
        held_data  = bus.ser_data;
        held_ctl   = bus.ser_ctl;
        bad        = 0;
        busy_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.deser_valid = (i == 3);
            bus.deser_A     = 32'hAAAA_AAAA;
            bus.deser_op    = 3'b001;
            bus.deser_err   = 6'd0;
            if (!bus.ser_valid || bus.ser_data !== held_data || bus.ser_ctl !== held_ctl) bad++;
            if (bus.deser_ready) busy_ready++;
        end
        bus.deser_valid = 1'b0;
        chk("frame held under back-pressure", 64'(bad), 64'd0);
        chk("deser_ready low while sending", 64'(busy_ready), 64'd0);
        handshake();
        expect_quiet("dropped command stays dropped", 8);

        // Reset in the middle of WAIT_ALU
        bus.deser_A     = 32'h0000_0011;
        bus.deser_B     = 32'h0000_0022;
        bus.deser_op    = 3'b100;
        bus.deser_err   = 6'd0;
        bus.deser_valid = 1'b1;
        @(posedge clk); #1;
        bus.deser_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("mid-op reset");
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'h0000_0033;
        expect_quiet("alu_done after reset ignored", 6);
        apply(vec_or, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
